cic_integ_decim: RTL and testbench

//  Front half of the DDC CIC decimator: N cascaded integrators at input rate plus decimation

---
 rtl/cic_integ_decim.sv | 101 ++++++++++
 tb/tb_cic_integ_decim.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_integ_decim.sv
// CIC integrator chain plus decimation phase counter and warm-up FSM; no backpressure, din is
// taken whenever din_valid=1. integ_out/integ_flag register on the R-th valid sample's edge.
module cic_integ_decim #(
  parameter int INBITWIDTH  = 16,
  parameter int EXTBITWIDTH = 43,
  parameter int N_STAGES    = 5,
  parameter int DEC_RATE    = 32,
  parameter int WARMUP_DECS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   din_valid,
  input  logic [INBITWIDTH-1:0]  din,
  input  logic                   sync,
  output logic [EXTBITWIDTH-1:0] integ_out,
  output logic                   integ_flag,
  output logic                   running
);

  localparam int PW = (DEC_RATE > 1) ? $clog2(DEC_RATE) : 1;
  // warm_cnt only needs to reach WARMUP_DECS-1 before the FSM leaves warm-up
  localparam int WW = (WARMUP_DECS > 1) ? $clog2(WARMUP_DECS) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DEC_RATE - 1);
  localparam logic [WW-1:0] WARM_LAST  = WW'((WARMUP_DECS > 0) ? WARMUP_DECS - 1 : 0);

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  logic [EXTBITWIDTH-1:0] acc [N_STAGES];
  logic [EXTBITWIDTH-1:0] din_ext;
  logic [EXTBITWIDTH-1:0] last_nxt;
  logic [PW-1:0]          phase;
  logic [WW-1:0]          warm_cnt;
  logic [0:0]             state;
  logic                   dec_event;

  assign din_ext   = {{(EXTBITWIDTH-INBITWIDTH){din[INBITWIDTH-1]}}, din};
  assign dec_event = din_valid && (phase == PHASE_LAST) && !sync;
  assign running   = (state == ST_RUN);

  // Value the last stage takes on this edge, so the event publishes the just-updated sum.
  generate
    if (N_STAGES == 1) begin : g_one
      assign last_nxt = acc[0] + din_ext;
    end else begin : g_multi
      assign last_nxt = acc[N_STAGES-1] + acc[N_STAGES-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_STAGES; k++) begin
        acc[k] <= '0;
      end
    end else if (din_valid) begin
      acc[0] <= acc[0] + din_ext;
      for (int k = 1; k < N_STAGES; k++) begin
        acc[k] <= acc[k] + acc[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      warm_cnt   <= '0;
      state      <= ST_WARMUP;
      integ_out  <= '0;
      integ_flag <= 1'b0;
    end else begin
      integ_flag <= 1'b0;
      if (sync) begin
        // A sample arriving with sync is the first sample of the new frame.
        phase    <= din_valid ? PW'(1) : '0;
        warm_cnt <= '0;
        state    <= ST_WARMUP;
      end else begin
        if (din_valid) begin
          phase <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
        end
        if (dec_event) begin
          integ_out  <= last_nxt;
          integ_flag <= (state == ST_RUN) || (WARMUP_DECS == 0);
        end
        if (state == ST_WARMUP) begin
          if (WARMUP_DECS == 0) begin
            state <= ST_RUN;
          end else if (dec_event) begin
            if (warm_cnt == WARM_LAST) begin
              state    <= ST_RUN;
              warm_cnt <= '0;
            end else begin
              warm_cnt <= warm_cnt + WW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_integ_decim.sv
// Randomised scoreboard bench for cic_integ_decim: two parameterisations share one stimulus
// stream; expectations come from a closed-form binomial model of the integrator cascade.
module tb_cic_integ_decim;

  localparam int IN_A = 8, EXT_A = 14, N_A = 3, R_A = 4, WD_A = 2;
  localparam int IN_B = 4, EXT_B = 8,  N_B = 1, R_B = 3, WD_B = 0;

  typedef struct {
    int     cnt;
    int     evts;
    int     edges;
    longint out;
  } mst_t;

  typedef struct {
    longint out;
    bit     flag;
    bit     run;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             sync;
  logic             din_valid;
  logic [7:0]       din_a;
  logic [3:0]       din_b;
  logic [EXT_A-1:0] integ_out_a;
  logic [EXT_B-1:0] integ_out_b;
  logic             integ_flag_a, integ_flag_b;
  logic             running_a, running_b;

  assign din_b = din_a[3:0];

  cic_integ_decim #(
    .INBITWIDTH(IN_A), .EXTBITWIDTH(EXT_A), .N_STAGES(N_A), .DEC_RATE(R_A), .WARMUP_DECS(WD_A)
  ) dut_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din_a), .sync(sync),
    .integ_out(integ_out_a), .integ_flag(integ_flag_a), .running(running_a)
  );

  cic_integ_decim #(
    .INBITWIDTH(IN_B), .EXTBITWIDTH(EXT_B), .N_STAGES(N_B), .DEC_RATE(R_B), .WARMUP_DECS(WD_B)
  ) dut_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din_b), .sync(sync),
    .integ_out(integ_out_b), .integ_flag(integ_flag_b), .running(running_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Every valid sample accepted since the last reset (sync does not clear integrators).
  logic [7:0] samples [$];
  exp_t       qa [$];
  exp_t       qb [$];
  longint     fa [$];
  longint     fb [$];
  mst_t       ma, mb;

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic longint msk(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sext(input logic [7:0] v, input int w);
    longint x;
    x = longint'(v) & msk(w);
    if (((x >> (w - 1)) & 1) != 0) x = x - (longint'(1) << w);
    return x;
  endfunction

  function automatic longint choose(input int m, input int k);
    longint r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * longint'(m - i) / longint'(i + 1);
    return r;
  endfunction

  // Last-stage value after n samples: sum over samples x_j * C(n-j, N-1), reduced mod 2^ext.
  function automatic longint cascade(input int n_st, input int in_w, input int ext);
    longint s;
    int     n;
    s = 0;
    n = samples.size();
    for (int j = 1; j <= n; j++) s = s + sext(samples[j-1], in_w) * choose(n - j, n_st - 1);
    return s & msk(ext);
  endfunction

  task automatic step(input int n_st, input int r, input int wd, input int ext, input int in_w,
                      inout mst_t m, input bit rs, input bit sy, input bit v,
                      output exp_t e);
    e.flag = 1'b0;
    if (rs) begin
      m.cnt = 0; m.evts = 0; m.edges = 0; m.out = 0;
    end else if (sy) begin
      m.cnt = v ? 1 : 0; m.evts = 0; m.edges = 0;
    end else begin
      if (v) m.cnt++;
      if (v && (m.cnt % r) == 0) begin
        m.out  = cascade(n_st, in_w, ext);
        m.evts++;
        e.flag = (m.evts > wd);
      end
      m.edges++;
    end
    e.out = m.out;
    e.run = (m.evts >= wd) && (m.edges >= 1);
  endtask

  task automatic drive(input bit rs, input bit sy, input bit v, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst = rs; sync = sy; din_valid = v; din_a = d;
    if (rs) samples.delete();
    else if (v) samples.push_back(d);
    step(N_A, R_A, WD_A, EXT_A, IN_A, ma, rs, sy, v, e);
    qa.push_back(e);
    if (e.flag) fa.push_back(e.out);
    step(N_B, R_B, WD_B, EXT_B, IN_B, mb, rs, sy, v, e);
    qb.push_back(e);
    if (e.flag) fb.push_back(e.out);
  endtask

  task automatic seg(input int cycles, input int pv, input int psync, input int prst,
                     input bit toggle, input bit const7);
    bit         rs, sy, v;
    logic [7:0] d;
    for (int i = 0; i < cycles; i++) begin
      rs = ($urandom_range(999, 0) < prst);
      sy = ($urandom_range(999, 0) < psync);
      v  = toggle ? (i % 2 == 0) : ($urandom_range(99, 0) < pv);
      d  = const7 ? 8'd7 : 8'($urandom);
      drive(rs, sy, v, d);
    end
  endtask

  // Monitor: per-edge state checks plus value checks whenever a strobe appears.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_integ_out", longint'(integ_out_a), e.out);
        chk("a_integ_flag", longint'(integ_flag_a), longint'(e.flag));
        chk("a_running", longint'(running_a), longint'(e.run));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_integ_out", longint'(integ_out_b), e.out);
        chk("b_integ_flag", longint'(integ_flag_b), longint'(e.flag));
        chk("b_running", longint'(running_b), longint'(e.run));
      end
      if (integ_flag_a) begin
        if (fa.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_strobe: got unexpected strobe value %0d, expected no strobe", integ_out_a);
        end else begin
          chk("a_strobe_value", longint'(integ_out_a), fa.pop_front());
        end
      end
      if (integ_flag_b) begin
        if (fb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_strobe: got unexpected strobe value %0d, expected no strobe", integ_out_b);
        end else begin
          chk("b_strobe_value", longint'(integ_out_b), fb.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sync = 1'b0; din_valid = 1'b0; din_a = '0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 8'd0);
    // constant din=7 every clock: exercises the 8-bit wrap on the single-stage instance
    seg(120, 100, 0, 0, 1'b0, 1'b1);
    seg(80, 0, 0, 0, 1'b1, 1'b0);
    seg(1500, 80, 20, 3, 1'b0, 1'b0);
    // sync mid-frame with a valid sample on the same edge
    seg(10, 100, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 8'($urandom));
    seg(40, 100, 0, 0, 1'b0, 1'b0);
    // reset while running, then warm-up again
    seg(30, 100, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'd5);
    seg(60, 100, 0, 0, 1'b0, 1'b0);
    seg(800, 95, 4, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #2;
    chk("a_pending_expectations", longint'(qa.size() + fa.size()), 0);
    chk("b_pending_expectations", longint'(qb.size() + fb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
